// File: rtl/core_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_seq_pkg
// Description : Shared types and constants for the core clock sequencer:
//               sequencer state encoding, phase-width helper and defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package core_seq_pkg;

    // Sequencer state encoding (fixed values are visible to debug tooling)
    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2,
        HALTED = 2'd3
    } seq_state_e;

    localparam int DIV_DEFAULT        = 4;
    localparam int RESET_HOLD_DEFAULT = 8;

    // Width of the phase counter for a DIV-phase instruction window
    function automatic int phase_w(input int div);
        return $clog2(div);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_clock_sequencer_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_sat_counter
// Description : CNT_W-bit saturating up-counter with synchronous clear and
//               increment enable. Holds at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,      // synchronous clear, active-high
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: step by one when enabled, unless already at all-ones
    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/core_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : core_clock_sequencer
// Description : Generates per-unit clock enables inside a fixed DIV-phase
//               instruction window from the single board clock, plus a
//               stretched core reset, run/halt/single-step control and a
//               saturating retired-window counter.
//               Legal ranges: DIV 2..16, RESET_HOLD_CYCLES 1..255.
// Revision    : 1.0 - initial release
// ============================================================================
module core_clock_sequencer
    import core_seq_pkg::*;
#(
    parameter int DIV               = DIV_DEFAULT,
    parameter int RESET_HOLD_CYCLES = RESET_HOLD_DEFAULT,
    parameter int CNT_W             = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      run_enable,
    input  logic                      halt_req,
    input  logic                      step_req,
    output logic                      core_reset,
    output logic                      imem_en,
    output logic                      dmem_en,
    output logic                      proc_en,
    output logic                      regfile_en,
    output logic [phase_w(DIV)-1:0]   phase,
    output logic                      halted,
    output logic [CNT_W-1:0]          cycle_count
);

    localparam int              PW           = phase_w(DIV);
    localparam logic [PW-1:0]   c_last_phase = PW'(DIV - 1);
    localparam logic [7:0]      c_hold_last  = 8'(RESET_HOLD_CYCLES - 1);

    seq_state_e     state_q,        state_d;
    logic [7:0]     hold_cnt_q,     hold_cnt_d;
    logic [PW-1:0]  phase_q,        phase_d;
    logic           halt_pending_q, halt_pending_d;

    logic           w_last_phase;
    logic           w_active;
    logic           w_stop_run;

    assign w_last_phase = (phase_q == c_last_phase);
    assign w_active     = (state_q == RUN) || (state_q == STEP);
    // A stop request seen in the final phase still ends this window, so the
    // pending flag and the live requests are treated as one condition.
    assign w_stop_run   = halt_pending_q || halt_req || !run_enable;

    // Next-state, phase and halt-pending logic for the sequencer FSM
    always_comb begin
        state_d        = state_q;
        hold_cnt_d     = hold_cnt_q;
        phase_d        = phase_q;
        halt_pending_d = halt_pending_q;

        case (state_q)
            HOLD: begin
                phase_d        = '0;
                halt_pending_d = 1'b0;
                hold_cnt_d     = hold_cnt_q + 8'd1;
                if (hold_cnt_q == c_hold_last) begin
                    state_d = (run_enable && !halt_req) ? RUN : HALTED;
                end
            end

            RUN: begin
                if (w_last_phase) begin
                    phase_d        = '0;
                    halt_pending_d = 1'b0;
                    if (w_stop_run) begin
                        state_d = HALTED;
                    end
                end else begin
                    phase_d        = phase_q + PW'(1);
                    halt_pending_d = w_stop_run;
                end
            end

            STEP: begin
                // Requests are ignored here; exactly one window runs
                halt_pending_d = 1'b0;
                if (w_last_phase) begin
                    phase_d = '0;
                    state_d = HALTED;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end

            HALTED: begin
                phase_d        = '0;
                halt_pending_d = 1'b0;
                if (step_req) begin
                    state_d = STEP;
                end else if (halt_req) begin
                    state_d = HALTED;
                end else if (run_enable) begin
                    state_d = RUN;
                end
            end

            default: begin
                state_d    = HOLD;
                hold_cnt_d = 8'd0;
                phase_d    = '0;
            end
        endcase
    end

    // Sequencer state registers with synchronous reset into HOLD
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= HOLD;
            hold_cnt_q     <= 8'd0;
            phase_q        <= '0;
            halt_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            phase_q        <= phase_d;
            halt_pending_q <= halt_pending_d;
        end
    end

    // Moore output decodes; enables only fire in the active states
    assign core_reset = (state_q == HOLD);
    assign imem_en    = w_active;
    assign dmem_en    = w_active;
    assign proc_en    = w_active && w_last_phase;
    assign regfile_en = w_active && w_last_phase;
    assign phase      = phase_q;
    assign halted     = (state_q == HALTED);

    // Retired-window counter, one count per proc_en pulse
    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_counter (
        .clk     (clock),
        .rst     (reset),
        .i_inc   (proc_en),
        .o_count (cycle_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_core_clock_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_clock_sequencer
// Description : Directed, table-driven bench for core_clock_sequencer
//               (DIV=4, RESET_HOLD_CYCLES=8), plus a CNT_W=4 instance
//               sharing the same stimulus for counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_clock_sequencer;

    logic        clock;
    logic        reset;
    logic        run_enable;
    logic        halt_req;
    logic        step_req;
    logic        core_reset, imem_en, dmem_en, proc_en, regfile_en, halted;
    logic [1:0]  phase;
    logic [31:0] cycle_count;

    logic        s_core_reset, s_imem_en, s_dmem_en, s_proc_en, s_regfile_en, s_halted;
    logic [1:0]  s_phase;
    logic [3:0]  s_cycle_count;

    int checks = 0;
    int errors = 0;

    core_clock_sequencer #(.DIV(4), .RESET_HOLD_CYCLES(8), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .run_enable(run_enable),
        .halt_req(halt_req), .step_req(step_req),
        .core_reset(core_reset), .imem_en(imem_en), .dmem_en(dmem_en),
        .proc_en(proc_en), .regfile_en(regfile_en), .phase(phase),
        .halted(halted), .cycle_count(cycle_count)
    );

    core_clock_sequencer #(.DIV(4), .RESET_HOLD_CYCLES(8), .CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .run_enable(run_enable),
        .halt_req(halt_req), .step_req(step_req),
        .core_reset(s_core_reset), .imem_en(s_imem_en), .dmem_en(s_dmem_en),
        .proc_en(s_proc_en), .regfile_en(s_regfile_en), .phase(s_phase),
        .halted(s_halted), .cycle_count(s_cycle_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        core_reset;
        logic        imem;
        logic        dmem;
        logic        proc;
        logic        regf;
        logic [1:0]  phase;
        logic        halted;
        logic [31:0] count;
    } outs_t;

    typedef struct {
        logic  run_en;
        logic  halt;
        logic  step;
        outs_t exp;
    } vec_t;

    vec_t tbl [13];

    function automatic outs_t mk(input logic cr, input logic im, input logic dm,
                                 input logic pr, input logic rf, input logic [1:0] ph,
                                 input logic ha, input logic [31:0] cnt);
        outs_t o;
        o.core_reset = cr; o.imem = im; o.dmem = dm; o.proc = pr; o.regf = rf;
        o.phase = ph; o.halted = ha; o.count = cnt;
        return o;
    endfunction

    function automatic outs_t actual();
        return {core_reset, imem_en, dmem_en, proc_en, regfile_en, phase, halted, cycle_count};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string name, input outs_t exp);
        chk(name, 64'(actual()), 64'(exp));
    endtask

    // Outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Cycle 0 is the first cycle with reset low; entry i gives the inputs
    // applied during cycle i and the outputs expected in that cycle.
    task automatic run_table();
        for (int i = 0; i < 13; i++) begin
            run_enable = tbl[i].run_en;
            halt_req   = tbl[i].halt;
            step_req   = tbl[i].step;
            chk_outs($sformatf("hold_seq[%0d]", i), tbl[i].exp);
            tick();
        end
    endtask

    initial begin
        int exp_cnt;
        int pulses;

        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 2'd0, 0, 0)};
        end
        tbl[8]  = '{1'b1, 1'b0, 1'b0, mk(0, 1, 1, 0, 0, 2'd0, 0, 0)};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, mk(0, 1, 1, 0, 0, 2'd1, 0, 0)};
        tbl[10] = '{1'b1, 1'b0, 1'b0, mk(0, 1, 1, 0, 0, 2'd2, 0, 0)};
        tbl[11] = '{1'b1, 1'b0, 1'b0, mk(0, 1, 1, 1, 1, 2'd3, 0, 0)};
        tbl[12] = '{1'b1, 1'b0, 1'b0, mk(0, 1, 1, 0, 0, 2'd0, 0, 1)};

        clock      = 1'b0;
        reset      = 1'b1;
        run_enable = 1'b1;
        halt_req   = 1'b0;
        step_req   = 1'b0;

        // Power-on: reset for two cycles, then the HOLD/RUN entry table
        tick();
        tick();
        reset = 1'b0;
        run_table();

        // Steady RUN through cycle 47 (40 cycles after RUN entry at cycle 8)
        exp_cnt = 1;
        pulses  = 0;
        for (int cyc = 13; cyc < 48; cyc++) begin
            logic p3;
            p3 = (((cyc - 8) % 4) == 3);
            chk_outs($sformatf("run_cyc%0d", cyc),
                     mk(0, 1, 1, p3, p3, 2'((cyc - 8) % 4), 0, 32'(exp_cnt)));
            if (proc_en) pulses++;
            if (p3) exp_cnt++;
            tick();
        end
        chk("run40_pulses_after_first", 64'(pulses), 64'd9);
        chk("run40_count", 64'(cycle_count), 64'd10);

        // One-cycle halt_req at phase 1: the window completes, then HALTED
        tick();
        halt_req = 1'b1;
        chk_outs("halt_at_ph1", mk(0, 1, 1, 0, 0, 2'd1, 0, 10));
        tick();
        halt_req = 1'b0;
        chk_outs("halt_ph2", mk(0, 1, 1, 0, 0, 2'd2, 0, 10));
        tick();
        chk_outs("halt_ph3_pulse", mk(0, 1, 1, 1, 1, 2'd3, 0, 10));
        tick();
        chk_outs("halted_entry", mk(0, 0, 0, 0, 0, 2'd0, 1, 11));
        run_enable = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (proc_en) pulses++;
        end
        chk("halted_no_pulses", 64'(pulses), 64'd0);
        chk_outs("halted_idle", mk(0, 0, 0, 0, 0, 2'd0, 1, 11));

        // Single step with concurrent halt_req; step_req held during STEP
        step_req = 1'b1;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) step_req = 1'b0;
            chk_outs($sformatf("step_ph%0d", k),
                     mk(0, 1, 1, k == 3, k == 3, 2'(k), 0, 11));
            tick();
        end
        chk_outs("step_done", mk(0, 0, 0, 0, 0, 2'd0, 1, 12));
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (proc_en) pulses++;
        end
        chk("step_no_extra", 64'(pulses), 64'd0);
        chk_outs("step_idle", mk(0, 0, 0, 0, 0, 2'd0, 1, 12));

        // Resume RUN, then reset in the middle of a window at phase 2
        run_enable = 1'b1;
        tick();
        chk_outs("resume_ph0", mk(0, 1, 1, 0, 0, 2'd0, 0, 12));
        tick();
        tick();
        chk_outs("pre_reset_ph2", mk(0, 1, 1, 0, 0, 2'd2, 0, 12));
        reset = 1'b1;
        tick();
        chk_outs("mid_reset", mk(1, 0, 0, 0, 0, 2'd0, 0, 0));
        reset = 1'b0;
        run_table();

        // run_enable low throughout HOLD lands in HALTED
        reset      = 1'b1;
        run_enable = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_outs($sformatf("hold_noren[%0d]", i), mk(1, 0, 0, 0, 0, 2'd0, 0, 0));
            tick();
        end
        chk_outs("hold_to_halted", mk(0, 0, 0, 0, 0, 2'd0, 1, 0));
        run_enable = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk_outs($sformatf("halted_to_run_ph%0d", k),
                     mk(0, 1, 1, k == 3, k == 3, 2'(k), 0, 0));
            tick();
        end
        chk("first_window_count", 64'(cycle_count), 64'd1);
        chk("small_first_count", 64'(s_cycle_count), 64'd1);

        // 19 more windows: 20 total; the 4-bit counter must stick at 15
        for (int k = 0; k < 76; k++) begin
            tick();
        end
        chk("count_20_windows", 64'(cycle_count), 64'd20);
        chk("small_count_saturated", 64'(s_cycle_count), 64'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
